// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared types: grant and FSM encodings, reset value default.
// Also provides WORD_WIDTH / TRUE / FALSE when not already defined.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_LOAD,
    GNT_STORE
  } gnt_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam int RST_VAL_DEF = 0;

endpackage

// File: rtl/mem_ctrl_sp_ram.sv
// sp_ram: single-port synchronous word RAM, registered read, no reset.
// Used by mem_ctrl as its backing store.
module sp_ram #(
  parameter int W      = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates CPU fetch/load/store strobes onto one sp_ram.
// Define MEM_ADDR_CHECK_EN to add a sticky fault port for bad addresses.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          W       = `WORD_WIDTH,
  parameter int          ADDR_W  = 10,
  parameter logic [W-1:0] RST_VAL = W'(RST_VAL_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pc_clk,
  input  logic         pc_en,
  input  logic [W-1:0] pc,
  output logic [W-1:0] read_inst,
  input  logic         load_clk,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  input  logic         store_clk,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
`ifdef MEM_ADDR_CHECK_EN
  output logic         fault,
`endif
  output logic         busy
);

  logic pc_clk_q, load_clk_q, store_clk_q;
  logic cap_f, cap_l, cap_s;
  logic pend_f, pend_l, pend_s;
  logic [W-1:0] fa_q, la_q, sa_q, sd_q;
  state_e state_q, state_d;
  gnt_e gnt_q, sel;
  logic do_gnt;
  logic [W-1:0] sel_a, acc_a_q, acc_d_q;
  logic sel_bad, bad_q;
  logic ram_en, ram_we;
  logic [W-1:0] ram_rdata, rd;

  assign cap_f = pc_clk & ~pc_clk_q & pc_en;
  assign cap_l = load_clk & ~load_clk_q & load_en;
  assign cap_s = store_clk & ~store_clk_q & store_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_clk_q    <= 1'b0;
      load_clk_q  <= 1'b0;
      store_clk_q <= 1'b0;
      fa_q        <= '0;
      la_q        <= '0;
      sa_q        <= '0;
      sd_q        <= '0;
    end else begin
      pc_clk_q    <= pc_clk;
      load_clk_q  <= load_clk;
      store_clk_q <= store_clk;
      if (cap_f) fa_q <= pc;
      if (cap_l) la_q <= l_addr;
      if (cap_s) begin
        sa_q <= s_addr;
        sd_q <= s_data;
      end
    end
  end

  // Fixed priority: stores first so a same-cycle load sees new data.
  always_comb begin
    sel   = GNT_NONE;
    sel_a = fa_q;
    if (pend_s) begin
      sel   = GNT_STORE;
      sel_a = sa_q;
    end else if (pend_l) begin
      sel   = GNT_LOAD;
      sel_a = la_q;
    end else if (pend_f) begin
      sel   = GNT_FETCH;
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  function automatic logic addr_bad(input logic [W-1:0] a);
    return (a[1:0] != 2'b00) || (a[W-1:ADDR_W+2] != '0);
  endfunction
  assign sel_bad = addr_bad(sel_a);
`else
  logic unused_addr;
  assign sel_bad     = `FALSE;
  assign unused_addr = ^{acc_a_q[1:0], acc_a_q[W-1:ADDR_W+2]};
`endif

  always_comb begin
    state_d = state_q;
    do_gnt  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel != GNT_NONE) begin
          do_gnt  = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (gnt_q != GNT_STORE) begin
          state_d = S_RESP;
        end else if (sel != GNT_NONE) begin
          do_gnt  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= GNT_NONE;
      acc_a_q <= '0;
      acc_d_q <= '0;
      bad_q   <= 1'b0;
      pend_f  <= 1'b0;
      pend_l  <= 1'b0;
      pend_s  <= 1'b0;
    end else begin
      state_q <= state_d;
      // A capture on the granted port re-arms it for the next slot.
      pend_f <= cap_f | (pend_f & ~(do_gnt & (sel == GNT_FETCH)));
      pend_l <= cap_l | (pend_l & ~(do_gnt & (sel == GNT_LOAD)));
      pend_s <= cap_s | (pend_s & ~(do_gnt & (sel == GNT_STORE)));
      if (do_gnt) begin
        gnt_q   <= sel;
        acc_a_q <= sel_a;
        acc_d_q <= sd_q;
        bad_q   <= sel_bad;
      end
    end
  end

  assign ram_en = (state_q == S_ACCESS) & ~bad_q;
  assign ram_we = (gnt_q == GNT_STORE);

  sp_ram #(
    .W      (W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (acc_a_q[ADDR_W+1:2]),
    .wdata (acc_d_q),
    .rdata (ram_rdata)
  );

  assign rd = bad_q ? RST_VAL : ram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_inst <= RST_VAL;
      l_data    <= RST_VAL;
    end else if (state_q == S_RESP) begin
      unique case (1'b1)
        gnt_q == GNT_FETCH: read_inst <= rd;
        gnt_q == GNT_LOAD:  l_data    <= rd;
        default: ;
      endcase
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 fault <= `FALSE;
    else if (do_gnt & sel_bad) fault <= `TRUE;
  end
`endif

  assign busy = pend_f | pend_l | pend_s | (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a
// word-array memory model with store-before-read ordering.
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int W  = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pc_clk = 1'b0, pc_en = 1'b0;
  logic load_clk = 1'b0, load_en = 1'b0;
  logic store_clk = 1'b0, store_en = 1'b0;
  logic [W-1:0] pc = '0, l_addr = '0, s_addr = '0, s_data = '0;
  logic [W-1:0] read_inst, l_data;
  logic busy;
`ifdef MEM_ADDR_CHECK_EN
  logic fault;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mdl [int];
  int known[$];
  logic [W-1:0] exp_inst = '0;

  mem_ctrl #(.W(W), .ADDR_W(AW), .RST_VAL('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_clk    (pc_clk),
    .pc_en     (pc_en),
    .pc        (pc),
    .read_inst (read_inst),
    .load_clk  (load_clk),
    .load_en   (load_en),
    .l_addr    (l_addr),
    .l_data    (l_data),
    .store_clk (store_clk),
    .store_en  (store_en),
    .s_addr    (s_addr),
    .s_data    (s_data),
`ifdef MEM_ADDR_CHECK_EN
    .fault     (fault),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  function automatic int widx(input logic [W-1:0] a);
    return int'((a >> 2) & ((1 << AW) - 1));
  endfunction

  function automatic logic [W-1:0] mk_addr(input int idx);
    logic [W-1:0] a;
    a = W'(idx) << 2;
`ifndef MEM_ADDR_CHECK_EN
    a[1:0] = 2'($urandom);
    a[W-1:AW+2] = 20'($urandom);
`endif
    return a;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input bit f, input bit l, input bit s,
                       input logic [W-1:0] fa, input logic [W-1:0] la,
                       input logic [W-1:0] sa, input logic [W-1:0] sd);
    pc = fa; l_addr = la; s_addr = sa; s_data = sd;
    pc_en = 1'b1; load_en = 1'b1; store_en = 1'b1;
    pc_clk = f; load_clk = l; store_clk = s;
    tick();
    pc_clk = 1'b0; load_clk = 1'b0; store_clk = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle timeout: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic mstore(input logic [W-1:0] a, input logic [W-1:0] d);
    issue(0, 0, 1, '0, '0, a, d);
    wait_idle("mstore");
    mdl[widx(a)] = d;
    known.push_back(widx(a));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks += 3;
    if (read_inst !== '0) begin
      errors++; $display("FAIL reset read_inst: got %h required 0", read_inst);
    end
    if (l_data !== '0) begin
      errors++; $display("FAIL reset l_data: got %h required 0", l_data);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset busy: got %b required 0", busy);
    end
`ifdef MEM_ADDR_CHECK_EN
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL reset fault: got %b required 0", fault);
    end
`endif
    rst = 1'b1;
    tick();
  endtask

  task automatic test_store_fetch();
    mstore(32'h10, 32'hDEADBEEF);
    issue(1, 0, 0, 32'h10, '0, '0, '0);
    tick(); tick();
    checks++;
    if (read_inst !== exp_inst) begin
      errors++; $display("FAIL fetch early: got %h required %h", read_inst, exp_inst);
    end
    tick();
    exp_inst = 32'hDEADBEEF;
    checks += 2;
    if (read_inst !== exp_inst) begin
      errors++; $display("FAIL fetch latency: got %h required %h", read_inst, exp_inst);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL fetch busy after: got %b required 0", busy);
    end
  endtask

  task automatic test_simul();
    bit seen_old;
    int n;
    mstore(32'h20, 32'hAAAAAAAA);
    issue(0, 1, 1, '0, 32'h20, 32'h20, 32'h12345678);
    seen_old = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      if (l_data === 32'hAAAAAAAA) seen_old = 1'b1;
      tick();
      n++;
    end
    mdl[widx(32'h20)] = 32'h12345678;
    checks += 3;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL simul idle: busy=%b required 0", busy);
    end
    if (l_data !== 32'h12345678) begin
      errors++; $display("FAIL simul l_data: got %h required 12345678", l_data);
    end
    if (seen_old) begin
      errors++; $display("FAIL simul stale: got AAAAAAAA required never");
    end
  endtask

  task automatic test_wrap();
    mstore(32'h0, 32'h0);
    issue(0, 0, 1, '0, '0, 32'h1000, 32'hCAFEF00D);
    wait_idle("wrap store");
    issue(0, 1, 0, '0, 32'h0, '0, '0);
    wait_idle("wrap load");
`ifdef MEM_ADDR_CHECK_EN
    checks += 2;
    if (fault !== 1'b1) begin
      errors++; $display("FAIL wrap fault: got %b required 1", fault);
    end
    if (l_data !== '0) begin
      errors++; $display("FAIL wrap l_data: got %h required 0", l_data);
    end
    issue(1, 0, 0, 32'h11, '0, '0, '0);
    wait_idle("misaligned fetch");
    exp_inst = '0;
    checks++;
    if (read_inst !== exp_inst) begin
      errors++; $display("FAIL misaligned read_inst: got %h required 0", read_inst);
    end
`else
    mdl[widx(32'h1000)] = 32'hCAFEF00D;
    checks++;
    if (l_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL wrap l_data: got %h required cafef00d", l_data);
    end
`endif
  endtask

  task automatic test_overwrite();
    logic [W-1:0] sd;
    bit seen4;
    int n;
    sd = $urandom;
    mstore(32'h4, 32'h44444444);
    mstore(32'h8, 32'h88888888);
    issue(1, 1, 1, 32'h4, 32'h20, 32'h40, sd);
    tick();
    issue(1, 0, 0, 32'h8, '0, '0, '0);
    seen4 = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      if (read_inst === 32'h44444444) seen4 = 1'b1;
      tick();
      n++;
    end
    mdl[widx(32'h40)] = sd;
    known.push_back(widx(32'h40));
    exp_inst = 32'h88888888;
    checks += 3;
    if (read_inst !== exp_inst) begin
      errors++; $display("FAIL overwrite read_inst: got %h required %h", read_inst, exp_inst);
    end
    if (seen4) begin
      errors++; $display("FAIL overwrite dropped: got 44444444 required never");
    end
    if (l_data !== mdl[widx(32'h20)]) begin
      errors++; $display("FAIL overwrite l_data: got %h required %h", l_data, mdl[widx(32'h20)]);
    end
    issue(0, 1, 0, '0, 32'h40, '0, '0);
    wait_idle("hold load");
    checks += 2;
    if (l_data !== sd) begin
      errors++; $display("FAIL hold l_data: got %h required %h", l_data, sd);
    end
    if (read_inst !== exp_inst) begin
      errors++; $display("FAIL hold read_inst: got %h required %h", read_inst, exp_inst);
    end
  endtask

  task automatic test_strobe_hold();
    int bc;
    pc = 32'h10; pc_en = 1'b1; pc_clk = 1'b1;
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) bc++;
      if (i == 4) pc_clk = 1'b0;
    end
    exp_inst = mdl[widx(32'h10)];
    checks += 2;
    if (bc != 3) begin
      errors++; $display("FAIL held strobe busy cycles: got %0d required 3", bc);
    end
    if (read_inst !== exp_inst) begin
      errors++; $display("FAIL held strobe read_inst: got %h required %h", read_inst, exp_inst);
    end
    pc = 32'h8; pc_en = 1'b0; pc_clk = 1'b1;
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy) bc++;
      if (i == 2) pc_clk = 1'b0;
    end
    pc_en = 1'b1;
    checks += 2;
    if (bc != 0) begin
      errors++; $display("FAIL disabled strobe busy cycles: got %0d required 0", bc);
    end
    if (read_inst !== exp_inst) begin
      errors++; $display("FAIL disabled strobe read_inst: got %h required %h", read_inst, exp_inst);
    end
  endtask

  task automatic test_reset_mid();
    int bc;
    issue(0, 1, 1, '0, 32'h20, 32'h200, 32'h5A5A5A5A);
    tick();
    #1 rst = 1'b0;
    #1;
    checks += 3;
    if (read_inst !== '0) begin
      errors++; $display("FAIL midreset read_inst: got %h required 0", read_inst);
    end
    if (l_data !== '0) begin
      errors++; $display("FAIL midreset l_data: got %h required 0", l_data);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midreset busy: got %b required 0", busy);
    end
    tick();
    rst = 1'b1;
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) bc++;
    end
    exp_inst = '0;
    checks += 2;
    if (bc != 0) begin
      errors++; $display("FAIL midreset serviced: busy cycles %0d required 0", bc);
    end
    if (l_data !== '0) begin
      errors++; $display("FAIL midreset l_data after: got %h required 0", l_data);
    end
`ifdef MEM_ADDR_CHECK_EN
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL midreset fault: got %b required 0", fault);
    end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int m, sidx;
      bit f, l, s;
      logic [W-1:0] fa, la, sa, sd, ex;
      m = $urandom_range(1, 7);
      f = m[0]; l = m[1]; s = m[2];
      sidx = $urandom_range(0, (1 << AW) - 1);
      sa = mk_addr(sidx);
      sd = $urandom;
      if (s && $urandom_range(0, 1) == 1) la = mk_addr(sidx);
      else la = mk_addr(known[$urandom_range(0, known.size() - 1)]);
      if (s && $urandom_range(0, 1) == 1) fa = mk_addr(sidx);
      else fa = mk_addr(known[$urandom_range(0, known.size() - 1)]);
      issue(f, l, s, fa, la, sa, sd);
      wait_idle("random");
      if (s) begin
        mdl[sidx] = sd;
        known.push_back(sidx);
      end
      if (l) begin
        ex = mdl[widx(la)];
        checks++;
        if (l_data !== ex) begin
          errors++; $display("FAIL random load %0d: got %h required %h", it, l_data, ex);
        end
      end
      if (f) begin
        ex = mdl[widx(fa)];
        checks++;
        if (read_inst !== ex) begin
          errors++; $display("FAIL random fetch %0d: got %h required %h", it, read_inst, ex);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_fetch();
    test_simul();
    test_wrap();
    test_overwrite();
    test_strobe_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
